// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl
//   Control FSM plus cascaded NDIG-digit BCD counter for the stopwatch display
//   path. An internal prescaler divides clk into count ticks; a lap command
//   freezes the display while the live count keeps advancing.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   synchronous active-low reset
//   start      in   begin/resume counting (IDLE/PAUSE -> RUN)
//   stop       in   pause counting (RUN -> PAUSE)
//   clear      in   zero everything, return to IDLE
//   lap        in   toggle lap freeze of the display
//   count      out  live BCD value, digit i at [4i+3:4i]
//   disp       out  lap snapshot while lap_active, else count
//   running    out  high while in RUN
//   lap_active out  display frozen
//   ovf        out  WRAP=1: one-cycle pulse on wrap; WRAP=0: sticky on halt
//   tick       out  combinational, high in the cycle a count step is taken
module bcd_stopwatch_ctrl #(
    parameter int NDIG     = 4,
    parameter int TICK_DIV = 10,
    parameter int WRAP     = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              lap,
    output logic [4*NDIG-1:0] count,
    output logic [4*NDIG-1:0] disp,
    output logic              running,
    output logic              lap_active,
    output logic              ovf,
    output logic              tick
);

    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t            state, state_nx;
    logic [PW-1:0]     presc, presc_nx;
    logic [4*NDIG-1:0] count_nx, inc_val, lap_reg, lap_reg_nx;
    logic              lap_active_nx, ovf_nx, all9, lap_ok;

    // Ripple BCD increment: the carry survives a digit only when that digit
    // is 9, so a carry out of the top digit means the value was all 9s.
    always_comb begin
        logic       carry;
        logic [3:0] dig;
        carry   = 1'b1;
        dig     = '0;
        inc_val = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            dig = count[4*i +: 4];
            if (carry) begin
                if (dig == 4'd9) begin
                    inc_val[4*i +: 4] = '0;
                end else begin
                    inc_val[4*i +: 4] = dig + 4'd1;
                    carry             = 1'b0;
                end
            end else begin
                inc_val[4*i +: 4] = dig;
            end
        end
        all9 = carry;
    end

    assign tick    = (state == RUN) && (presc == PW'(TICK_DIV - 1)) && !stop && !clear;
    assign running = (state == RUN);
    assign disp    = lap_active ? lap_reg : count;

    always_comb begin
        state_nx      = state;
        presc_nx      = presc;
        count_nx      = count;
        lap_reg_nx    = lap_reg;
        lap_active_nx = lap_active;
        // Wrapping mode pulses ovf for a single cycle; halting mode keeps it.
        ovf_nx        = (WRAP != 0) ? 1'b0 : ovf;
        lap_ok        = 1'b0;

        if (clear) begin
            state_nx      = IDLE;
            presc_nx      = '0;
            count_nx      = '0;
            lap_reg_nx    = '0;
            lap_active_nx = 1'b0;
            ovf_nx        = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    presc_nx = '0;
                    if (start) state_nx = RUN;
                end
                RUN: begin
                    // stop outranks a due tick and also freezes the prescaler
                    if (stop) begin
                        state_nx = PAUSE;
                    end else begin
                        lap_ok   = lap;
                        presc_nx = (presc == PW'(TICK_DIV - 1)) ? '0 : presc + PW'(1);
                        if (tick) begin
                            if (all9 && (WRAP == 0)) begin
                                state_nx = DONE;
                                ovf_nx   = 1'b1;
                            end else begin
                                count_nx = inc_val;
                                if (all9) ovf_nx = 1'b1;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (!stop) begin
                        lap_ok = lap;
                        if (start) state_nx = RUN;
                    end
                end
                default: ;
            endcase
        end

        // Snapshot uses the pre-increment count when lap coincides with tick.
        if (lap_ok) begin
            lap_active_nx = !lap_active;
            if (!lap_active) lap_reg_nx = count;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            presc      <= '0;
            count      <= '0;
            lap_reg    <= '0;
            lap_active <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state      <= state_nx;
            presc      <= presc_nx;
            count      <= count_nx;
            lap_reg    <= lap_reg_nx;
            lap_active <= lap_active_nx;
            ovf        <= ovf_nx;
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
module tb_bcd_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
    logic [15:0] count_w, disp_w, count_h, disp_h;
    logic        running_w, lap_active_w, ovf_w, tick_w;
    logic        running_h, lap_active_h, ovf_h, tick_h;
    int          total = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    bcd_stopwatch_ctrl #(.NDIG(4), .TICK_DIV(2), .WRAP(1)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .count(count_w), .disp(disp_w), .running(running_w), .lap_active(lap_active_w),
        .ovf(ovf_w), .tick(tick_w)
    );

    bcd_stopwatch_ctrl #(.NDIG(4), .TICK_DIV(2), .WRAP(0)) dut_halt (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .count(count_h), .disp(disp_h), .running(running_h), .lap_active(lap_active_h),
        .ovf(ovf_h), .tick(tick_h)
    );

    // Advance to 1 time unit after the next rising edge; commands are 1-cycle pulses.
    task automatic next();
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
    endtask

    task automatic wait_count(input logic [15:0] target, input int budget, input string name);
        int n = 0;
        while (count_w !== target && n < budget) begin
            next();
            n++;
        end
        total++;
        if (count_w !== target) $display("FAIL %s: count got %h expected %h", name, count_w, target);
        else passed++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        next(); next();
        total++; if (count_w !== 16'h0000) $display("FAIL reset_count: got %h expected 0000", count_w); else passed++;
        total++; if (disp_w !== 16'h0000) $display("FAIL reset_disp: got %h expected 0000", disp_w); else passed++;
        total++; if ({running_w, lap_active_w, ovf_w, tick_w} !== 4'b0000)
            $display("FAIL reset_flags: got %b expected 0000", {running_w, lap_active_w, ovf_w, tick_w}); else passed++;
        total++; if ({running_h, ovf_h} !== 2'b00) $display("FAIL reset_halt_flags: got %b expected 00", {running_h, ovf_h}); else passed++;
        reset_n = 1'b1;
        next();
    endtask

    // start in cycle 0: RUN at 1, ticks at 2,4,6, count k visible at 2k+1
    task automatic test_latency();
        logic        exp_tick;
        logic [15:0] exp_count;
        start = 1'b1;
        #1;
        total++; if (running_w !== 1'b0) $display("FAIL lat_idle: running got %b expected 0", running_w); else passed++;
        for (int c = 1; c <= 7; c++) begin
            next();
            exp_tick  = (c >= 2) && (c % 2 == 0);
            exp_count = (c >= 3) ? 16'((c - 1) / 2) : 16'h0000;
            total++; if (running_w !== 1'b1) $display("FAIL lat_running c%0d: got %b expected 1", c, running_w); else passed++;
            total++; if (tick_w !== exp_tick) $display("FAIL lat_tick c%0d: got %b expected %b", c, tick_w, exp_tick); else passed++;
            total++; if (count_w !== exp_count) $display("FAIL lat_count c%0d: got %h expected %h", c, count_w, exp_count); else passed++;
        end
    endtask

    task automatic test_lap();
        wait_count(16'h0015, 100, "lap_reach15");
        lap = 1'b1;
        next();
        total++; if (lap_active_w !== 1'b1) $display("FAIL lap_on: got %b expected 1", lap_active_w); else passed++;
        total++; if (disp_w !== 16'h0015) $display("FAIL lap_disp: got %h expected 0015", disp_w); else passed++;
        wait_count(16'h0020, 100, "lap_reach20");
        total++; if (disp_w !== 16'h0015) $display("FAIL lap_frozen: got %h expected 0015", disp_w); else passed++;
        lap = 1'b1;
        next();
        total++; if (lap_active_w !== 1'b0) $display("FAIL lap_off: got %b expected 0", lap_active_w); else passed++;
        total++; if (disp_w !== 16'h0020) $display("FAIL lap_track: got %h expected 0020", disp_w); else passed++;
    endtask

    task automatic test_stop_on_tick();
        wait_count(16'h0042, 100, "stop_reach42");
        next();
        total++; if (tick_w !== 1'b1) $display("FAIL stop_tick_due: got %b expected 1", tick_w); else passed++;
        stop = 1'b1;
        #1;
        total++; if (tick_w !== 1'b0) $display("FAIL stop_suppress: got %b expected 0", tick_w); else passed++;
        next();
        total++; if (running_w !== 1'b0) $display("FAIL stop_paused: running got %b expected 0", running_w); else passed++;
        total++; if (count_w !== 16'h0042) $display("FAIL stop_hold: got %h expected 0042", count_w); else passed++;
        next();
        total++; if (count_w !== 16'h0042) $display("FAIL stop_hold2: got %h expected 0042", count_w); else passed++;
        start = 1'b1;
        next();
        // prescaler held at TICK_DIV-1, so the tick is due in the first RUN cycle
        total++; if (tick_w !== 1'b1) $display("FAIL resume_tick: got %b expected 1", tick_w); else passed++;
        next();
        total++; if (count_w !== 16'h0043) $display("FAIL resume_count: got %h expected 0043", count_w); else passed++;
    endtask

    task automatic test_carry();
        wait_count(16'h0099, 200, "carry_reach99");
        next();
        total++; if (tick_w !== 1'b1) $display("FAIL carry_tick: got %b expected 1", tick_w); else passed++;
        next();
        total++; if (count_w !== 16'h0100) $display("FAIL carry_count: got %h expected 0100", count_w); else passed++;
    endtask

    task automatic test_overflow();
        wait_count(16'h9999, 25000, "ovf_reach9999");
        total++; if (count_h !== 16'h9999) $display("FAIL halt_reach: got %h expected 9999", count_h); else passed++;
        next();
        total++; if ({tick_w, tick_h} !== 2'b11) $display("FAIL ovf_tick: got %b expected 11", {tick_w, tick_h}); else passed++;
        next();
        total++; if (count_w !== 16'h0000) $display("FAIL wrap_count: got %h expected 0000", count_w); else passed++;
        total++; if ({ovf_w, running_w} !== 2'b11) $display("FAIL wrap_flags: got %b expected 11", {ovf_w, running_w}); else passed++;
        total++; if (count_h !== 16'h9999) $display("FAIL halt_count: got %h expected 9999", count_h); else passed++;
        total++; if ({ovf_h, running_h} !== 2'b10) $display("FAIL halt_flags: got %b expected 10", {ovf_h, running_h}); else passed++;
        next();
        total++; if (ovf_w !== 1'b0) $display("FAIL wrap_pulse: ovf got %b expected 0", ovf_w); else passed++;
        total++; if (ovf_h !== 1'b1) $display("FAIL halt_sticky: ovf got %b expected 1", ovf_h); else passed++;
        start = 1'b1;
        next();
        total++; if ({running_h, count_h} !== {1'b0, 16'h9999})
            $display("FAIL done_start: got %b/%h expected 0/9999", running_h, count_h); else passed++;
        clear = 1'b1;
        next();
        total++; if ({count_h, ovf_h, running_h} !== {16'h0000, 2'b00})
            $display("FAIL halt_clear: got %h/%b/%b expected 0000/0/0", count_h, ovf_h, running_h); else passed++;
        total++; if ({count_w, running_w} !== {16'h0000, 1'b0})
            $display("FAIL wrap_clear: got %h/%b expected 0000/0", count_w, running_w); else passed++;
    endtask

    task automatic test_priority_and_reset();
        lap = 1'b1;
        next();
        total++; if (lap_active_w !== 1'b0) $display("FAIL idle_lap: got %b expected 0", lap_active_w); else passed++;
        start = 1'b1;
        next();
        total++; if (running_w !== 1'b1) $display("FAIL prio_run: got %b expected 1", running_w); else passed++;
        next(); next();
        total++; if (count_w !== 16'h0001) $display("FAIL prio_pre: got %h expected 0001", count_w); else passed++;
        start = 1'b1; stop = 1'b1; clear = 1'b1;
        next();
        total++; if ({running_w, count_w} !== {1'b0, 16'h0000})
            $display("FAIL prio_clear: got %b/%h expected 0/0000", running_w, count_w); else passed++;
        start = 1'b1;
        next();
        wait_count(16'h0123, 400, "rst_reach123");
        reset_n = 1'b0;
        lap = 1'b1;
        next();
        reset_n = 1'b1;
        total++; if (count_w !== 16'h0000) $display("FAIL midrun_reset_count: got %h expected 0000", count_w); else passed++;
        total++; if ({running_w, lap_active_w, ovf_w, tick_w} !== 4'b0000)
            $display("FAIL midrun_reset_flags: got %b expected 0000", {running_w, lap_active_w, ovf_w, tick_w}); else passed++;
        next();
        total++; if (running_w !== 1'b0) $display("FAIL post_reset_idle: got %b expected 0", running_w); else passed++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_lap();
        test_stop_on_tick();
        test_carry();
        test_overflow();
        test_priority_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
